// File: rtl/fft_out_reorder.sv
// rtl/fft_out_reorder.sv - ping-pong reorder buffer: bit-reversed input frames out in natural order
// Optional feature macro: FFT_REORDER_OVF_EN (drop-on-busy frame detection and sticky ovf flag).
// Without the macro the writer always takes its target bank and ovf is tied 0.

`ifndef CPLX_WIDTH
`define CPLX_WIDTH 32
`endif

module fft_out_reorder #(
  parameter int FFT_STG = 7,
  parameter int DATA_W  = `CPLX_WIDTH
) (
  input  logic               iclk,
  input  logic               rst,
  input  logic               ien,
  input  logic [FFT_STG-1:0] iaddr,
  input  logic [DATA_W-1:0]  idata,
  output logic               oen,
  input  logic               ordy,
  output logic [FFT_STG-1:0] oaddr,
  output logic [DATA_W-1:0]  odata,
  output logic               olast,
  output logic               ovf
);

  localparam int                 N        = 1 << FFT_STG;
  localparam logic [FFT_STG-1:0] LAST_IDX = {FFT_STG{1'b1}};

  typedef enum logic [1:0] {
    B_FREE    = 2'd0,
    B_FILLING = 2'd1,
    B_FULL    = 2'd2,
    B_READING = 2'd3
  } bank_st_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RUN  = 1'b1
  } rd_st_t;

  function automatic logic [FFT_STG-1:0] bitrev(input logic [FFT_STG-1:0] a);
    logic [FFT_STG-1:0] r;
    for (int i = 0; i < FFT_STG; i++) begin
      r[i] = a[FFT_STG-1-i];
    end
    return r;
  endfunction

  // Storage and bank bookkeeping
  logic [DATA_W-1:0]  r_mem [0:1][0:N-1];
  bank_st_t           r_bank [0:1];

  // Writer side
  logic [FFT_STG-1:0] r_wcnt;
  logic               r_wb;
  logic               r_drop;
  logic               w_fstart;
  logic               w_fend;
  logic               w_accept;
  logic               w_frame_drop;
  logic               w_we;
  logic [FFT_STG-1:0] w_wr_idx;

  // Reader side
  rd_st_t             r_rstate;
  rd_st_t             w_rstate_nxt;
  logic               r_rb;
  logic               r_oen;
  logic               r_olast;
  logic [FFT_STG-1:0] r_oaddr;
  logic [DATA_W-1:0]  r_rd_data;
  logic               w_rstart;
  logic               w_xfer;
  logic               w_rel;
  logic               w_rd_en;
  logic [FFT_STG-1:0] w_rd_addr;

  assign w_fstart = ien && (r_wcnt == '0);
  assign w_fend   = ien && (r_wcnt == LAST_IDX);
  assign w_wr_idx = bitrev(iaddr);

`ifdef FFT_REORDER_OVF_EN
  logic w_wb_free;
  logic r_ovf;

  // A bank released by the reader on this very edge counts as free for a frame start.
  assign w_wb_free = (r_bank[r_wb] == B_FREE) || (w_rel && (r_rb == r_wb));
  assign w_accept  = w_wb_free;

  // Sticky overflow: set by the first frame start that finds its bank busy.
  always_ff @(posedge iclk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_fstart && !w_accept) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`else
  assign w_accept = 1'b1;
  assign ovf      = 1'b0;
`endif

  // The drop decision is made at frame start and held for the rest of the frame.
  assign w_frame_drop = w_fstart ? !w_accept : r_drop;
  assign w_we         = ien && !w_frame_drop && !rst;

  // Writer frame counter, target bank and per-frame drop flag.
  always_ff @(posedge iclk) begin
    if (rst) begin
      r_wcnt <= '0;
      r_wb   <= 1'b0;
      r_drop <= 1'b0;
    end else if (ien) begin
      r_wcnt <= r_wcnt + 1'b1;
      if (w_fstart) begin
        r_drop <= !w_accept;
      end
      if (w_fend && !w_frame_drop) begin
        r_wb <= ~r_wb;
      end
    end
  end

  // Sample RAM write port; samples land at their natural-order position.
  always_ff @(posedge iclk) begin
    if (w_we) begin
      r_mem[r_wb][w_wr_idx] <= idata;
    end
  end

  // Bank lifecycle; writer claims take priority over reader transitions on the same bank.
  always_ff @(posedge iclk) begin
    for (int b = 0; b < 2; b++) begin
      if (rst) begin
        r_bank[b] <= B_FREE;
      end else if (w_fstart && w_accept && (r_wb == 1'(b))) begin
        r_bank[b] <= B_FILLING;
      end else if (w_fend && !w_frame_drop && (r_wb == 1'(b))) begin
        r_bank[b] <= B_FULL;
      end else if (w_rstart && (r_rb == 1'(b))) begin
        r_bank[b] <= B_READING;
      end else if (w_rel && (r_rb == 1'(b)) && (r_bank[b] == B_READING)) begin
        r_bank[b] <= B_FREE;
      end
    end
  end

  // Reader FSM state register.
  always_ff @(posedge iclk) begin
    if (rst) begin
      r_rstate <= R_IDLE;
    end else begin
      r_rstate <= w_rstate_nxt;
    end
  end

  // Reader next state and read-port control; the read address only moves on a transfer.
  always_comb begin
    w_rstate_nxt = r_rstate;
    w_rstart     = 1'b0;
    w_xfer       = 1'b0;
    w_rel        = 1'b0;
    w_rd_en      = 1'b0;
    w_rd_addr    = r_oaddr;
    case (r_rstate)
      R_IDLE: begin
        if (r_bank[r_rb] == B_FULL) begin
          w_rstart     = 1'b1;
          w_rd_en      = 1'b1;
          w_rd_addr    = '0;
          w_rstate_nxt = R_RUN;
        end
      end
      R_RUN: begin
        w_xfer = r_oen && ordy;
        if (w_xfer) begin
          if (r_olast) begin
            w_rel        = 1'b1;
            w_rstate_nxt = R_IDLE;
          end else begin
            w_rd_en   = 1'b1;
            w_rd_addr = r_oaddr + 1'b1;
          end
        end
      end
      default: begin
        w_rstate_nxt = R_IDLE;
      end
    endcase
  end

  // Output handshake registers and read-bank pointer.
  always_ff @(posedge iclk) begin
    if (rst) begin
      r_rb    <= 1'b0;
      r_oen   <= 1'b0;
      r_olast <= 1'b0;
      r_oaddr <= '0;
    end else if (w_rstart) begin
      r_oen   <= 1'b1;
      r_olast <= (LAST_IDX == '0);
      r_oaddr <= '0;
    end else if (w_xfer) begin
      if (w_rel) begin
        r_oen   <= 1'b0;
        r_olast <= 1'b0;
        r_rb    <= ~r_rb;
      end else begin
        r_oaddr <= w_rd_addr;
        r_olast <= (w_rd_addr == LAST_IDX);
      end
    end
  end

  // Synchronous RAM read; the registered word is the presented sample and holds while stalled.
  always_ff @(posedge iclk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (w_rd_en) begin
      r_rd_data <= r_mem[r_rb][w_rd_addr];
    end
  end

  assign oen   = r_oen;
  assign oaddr = r_oaddr;
  assign odata = r_rd_data;
  assign olast = r_olast;

endmodule

// File: tb/tb_fft_out_reorder.sv
// tb/tb_fft_out_reorder.sv - self-checking bench for fft_out_reorder (FFT_STG=3) against a frame-level model

module tb_fft_out_reorder;

  localparam int STG = 3;
  localparam int N   = 8;
  localparam int DW  = 16;

  logic          iclk = 1'b0;
  logic          rst;
  logic          ien;
  logic [STG-1:0] iaddr;
  logic [DW-1:0] idata;
  logic          oen;
  logic          ordy;
  logic [STG-1:0] oaddr;
  logic [DW-1:0] odata;
  logic          olast;
  logic          ovf;

  always #5 iclk = ~iclk;

  fft_out_reorder #(.FFT_STG(STG), .DATA_W(DW)) dut (
    .iclk (iclk),
    .rst  (rst),
    .ien  (ien),
    .iaddr(iaddr),
    .idata(idata),
    .oen  (oen),
    .ordy (ordy),
    .oaddr(oaddr),
    .odata(odata),
    .olast(olast),
    .ovf  (ovf)
  );

  typedef struct {
    int addr;
    int data;
    bit known;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   frames_out  = 0;
  int   wcnt        = 0;
  bit   drop        = 0;
  bit   exp_ovf     = 0;
  int   fr_data [N];
  bit   fr_known[N];

  bit   prev_oen  = 0;
  bit   prev_ordy = 0;
  int   prev_addr = 0;
  int   prev_data = 0;

  int   obs_n;
  int   obs_addr[64];
  int   obs_data[64];
  int   obs_edge[64];
  int   last_ien_edge;
  int   first_oen_edge;

  function automatic int bitrev3(input int a);
    return ((a & 1) << 2) | (a & 2) | ((a >> 2) & 1);
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic clear_obs();
    obs_n          = 0;
    first_oen_edge = -1;
  endtask

  // One clock: compare DUT outputs with the model, drive inputs, advance the model for the coming edge.
  task automatic step(input bit r, input bit e, input int a, input int d, input bit rd);
    if (oen) begin
      if (exp_q.size() == 0) begin
        chk("spurious_oen", 1, 0);
      end else begin
        chk("oaddr", int'(oaddr), exp_q[0].addr);
        chk("olast", int'(olast), int'(exp_q[0].last));
        if (exp_q[0].known) chk("odata", int'(odata), exp_q[0].data);
      end
      if (first_oen_edge < 0) first_oen_edge = cyc + 1;
    end
    if (prev_oen && !prev_ordy) begin
      chk("hold_oen", int'(oen), 1);
      chk("hold_oaddr", int'(oaddr), prev_addr);
      chk("hold_odata", int'(odata), prev_data);
    end
    chk("ovf", int'(ovf), int'(exp_ovf));

    rst   = r;
    ien   = e;
    iaddr = a[STG-1:0];
    idata = d[DW-1:0];
    ordy  = rd;
    prev_oen  = oen && !r;
    prev_ordy = rd;
    prev_addr = int'(oaddr);
    prev_data = int'(odata);

    if (r) begin
      exp_q.delete();
      frames_out = 0;
      wcnt       = 0;
      drop       = 0;
      exp_ovf    = 0;
    end else begin
      if (oen && rd && exp_q.size() > 0) begin
        if (obs_n < 64) begin
          obs_addr[obs_n] = int'(oaddr);
          obs_data[obs_n] = int'(odata);
          obs_edge[obs_n] = cyc + 1;
        end
        obs_n++;
        if (exp_q[0].last) frames_out--;
        void'(exp_q.pop_front());
      end
      if (e) begin
        if (wcnt == 0) begin
`ifdef FFT_REORDER_OVF_EN
          drop = (frames_out >= 2);
          if (drop) exp_ovf = 1;
`else
          drop = 0;
`endif
          if (!drop) begin
            frames_out++;
            for (int i = 0; i < N; i++) fr_known[i] = 0;
          end
        end
        if (!drop) begin
          fr_data[bitrev3(a)]  = d & 16'hffff;
          fr_known[bitrev3(a)] = 1;
        end
        last_ien_edge = cyc + 1;
        if (wcnt == N - 1 && !drop) begin
          for (int i = 0; i < N; i++) begin
            exp_t x;
            x.addr  = i;
            x.data  = fr_data[i];
            x.known = fr_known[i];
            x.last  = (i == N - 1);
            exp_q.push_back(x);
          end
        end
        wcnt = (wcnt + 1) % N;
      end
    end
    @(posedge iclk);
    cyc++;
    @(negedge iclk);
  endtask

  task automatic drain(input string nm);
    int guard = 0;
    while ((exp_q.size() > 0 || oen) && guard < 300) begin
      step(0, 0, 0, 0, 1);
      guard++;
    end
    if (guard >= 300) chk({nm, "_drain_timeout"}, 1, 0);
  endtask

  task automatic send_frame(input int base, input bit rd);
    for (int k = 0; k < N; k++) step(0, 1, k, bitrev3(k) + base, rd);
  endtask

  initial begin
    int seq[8];
    int starts[3];
    int ns;
    int tog;
    int guard;

    rst   = 1;
    ien   = 0;
    iaddr = '0;
    idata = '0;
    ordy  = 0;
    repeat (2) @(posedge iclk);
    @(negedge iclk);
    chk("reset_oen", int'(oen), 0);
    chk("reset_olast", int'(olast), 0);
    chk("reset_oaddr", int'(oaddr), 0);
    chk("reset_odata", int'(odata), 0);
    chk("reset_ovf", int'(ovf), 0);
    step(1, 0, 0, 0, 1);

    // Single frame, ordy high: latency, natural order, data pinned to literals.
    clear_obs();
    send_frame(16'h10, 1);
    drain("t1");
    chk("t1_latency", first_oen_edge - last_ien_edge, 2);
    chk("t1_count", obs_n, 8);
    for (int i = 0; i < 8; i++) begin
      chk("t1_addr", obs_addr[i], i);
      chk("t1_data", obs_data[i], 16'h10 + i);
    end

    // Three back-to-back frames: one idle cycle between output frames.
    clear_obs();
    send_frame(16'h100, 1);
    send_frame(16'h200, 1);
    send_frame(16'h300, 1);
    drain("t2");
    chk("t2_count", obs_n, 24);
    ns = 0;
    for (int i = 0; i < 24 && i < 64; i++) begin
      if (obs_addr[i] == 0 && ns < 3) begin
        starts[ns] = obs_edge[i];
        ns++;
      end
    end
    chk("t2_frames", ns, 3);
    if (ns == 3) begin
      chk("t2_gap1", starts[1] - starts[0], N + 1);
      chk("t2_gap2", starts[2] - starts[1], N + 1);
    end
    chk("t2_data_f3_a5", obs_data[21], 16'h305);

    // Stalls during drain: ordy pattern 1,0,0,1.
    clear_obs();
    send_frame(16'h40, 0);
    tog = 0;
    guard = 0;
    while ((exp_q.size() > 0 || oen) && guard < 200) begin
      step(0, 0, 0, 0, (tog % 4 == 0) || (tog % 4 == 3));
      tog++;
      guard++;
    end
    if (guard >= 200) chk("t3_drain_timeout", 1, 0);
    chk("t3_count", obs_n, 8);
    for (int i = 0; i < 8; i++) chk("t3_addr", obs_addr[i], i);

`ifdef FFT_REORDER_OVF_EN
    // Consumer stalled across three frames: third frame dropped, ovf sticky.
    clear_obs();
    send_frame(16'h500, 0);
    send_frame(16'h600, 0);
    send_frame(16'h700, 0);
    step(0, 0, 0, 0, 0);
    chk("t4_ovf", int'(ovf), 1);
    drain("t4");
    chk("t4_count", obs_n, 16);
    chk("t4_f1_a3", obs_data[3], 16'h503);
    chk("t4_f2_a6", obs_data[14], 16'h606);
    chk("t4_ovf_sticky", int'(ovf), 1);
    step(1, 0, 0, 0, 1);
`endif

    // Reset mid-frame while a previous frame drains.
    clear_obs();
    send_frame(16'h80, 1);
    for (int k = 0; k < 5; k++) step(0, 1, k, 16'h90 + k, 1);
    step(1, 0, 0, 0, 1);
    chk("t5_oen", int'(oen), 0);
    chk("t5_olast", int'(olast), 0);
    chk("t5_oaddr", int'(oaddr), 0);
    chk("t5_odata", int'(odata), 0);
    chk("t5_ovf", int'(ovf), 0);
    clear_obs();
    send_frame(16'hC0, 1);
    drain("t5");
    chk("t5_count", obs_n, 8);
    chk("t5_first_addr", obs_addr[0], 0);
    chk("t5_first_data", obs_data[0], 16'hC0);

    // Duplicate bit-reversed index 1: last write wins, frame still closes after 8 samples.
    clear_obs();
    seq = '{0, 1, 2, 3, 1, 5, 6, 7};
    for (int k = 0; k < 8; k++) begin
      step(0, 1, seq[k], (k == 1) ? 16'hAA : ((k == 4) ? 16'hBB : 16'h20 + k), 1);
    end
    drain("t6");
    chk("t6_count", obs_n, 8);
    chk("t6_addr4_data", obs_data[4], 16'hBB);

    // Randomised traffic with random backpressure.
    clear_obs();
    for (int c = 0; c < 600; c++) begin
      bit e;
      bit rd;
      e  = ($urandom_range(0, 99) < 70);
      rd = ($urandom_range(0, 99) < 60);
`ifndef FFT_REORDER_OVF_EN
      if (wcnt == 0 && frames_out >= 2) e = 0;
`endif
      step(0, e, $urandom_range(0, N - 1), $urandom_range(0, 16'hffff), rd);
    end
    while (wcnt != 0) step(0, 1, $urandom_range(0, N - 1), $urandom_range(0, 16'hffff), 1);
    drain("t7");
    chk("t7_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/fft_out_reorder.md
# fft_out_reorder

Output reorder buffer placed directly downstream of the final `fft_stageX` instance. It accepts the address-tagged, bit-reversed-order complex stream produced by the last stage and emits each frame in natural order, 0..N-1, with a valid/ready handshake to the consumer. Two RAM banks (ping-pong) let one frame fill while the previous frame drains. Upstream has no stall input, so a frame arriving when no bank is free is dropped as a unit and flagged.

## Interface
- `FFT_STG`, default 7: log2 of the frame length; N = 2^FFT_STG.
- `DATA_W`, default `CPLX_WIDTH`: complex sample width, {re, im}.
- `iclk`  in  1: clock; all logic is on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `ien`  in  1: input sample valid; one sample per asserted cycle; no backpressure.
- `iaddr`  in  FFT_STG: bit-reversed index k of the sample; natural index is bitrev(k).
- `idata`  in  DATA_W: input sample.
- `oen`  out  1: output valid.
- `ordy`  in  1: consumer ready; a transfer occurs when `oen & ordy`.
- `oaddr`  out  FFT_STG: natural-order index of `odata`.
- `odata`  out  DATA_W: output sample.
- `olast`  out  1: high with `oen` when `oaddr` == N-1.
- `ovf`  out  1: sticky overflow flag; see Configuration.

## Operation
- Storage: 2 banks × N × DATA_W, with synchronous read and synchronous write.
- Each bank has a state: FREE → FILLING → FULL → READING → FREE.
- Writer frame counter `wcnt` (FFT_STG bits):
  - Advances on every `ien`, whether the sample is written or dropped.
  - Wraps from N-1 to 0.
  - Samples are counted, not addresses; duplicate `iaddr` within a frame overwrites the earlier sample and still counts.
- Frame start (`ien` with `wcnt` == 0): the writer targets bank `wb` (initially 0).
  - If that bank is FREE, it goes to FILLING and the sample is written to `mem[wb][bitrev(iaddr)]`.
  - Otherwise the whole frame is in DROP mode: all N samples are discarded and `ovf` is set.
- Frame end (N-th sample, `wcnt` == N-1): a FILLING bank becomes FULL and `wb` toggles. A dropped frame leaves `wb` unchanged.
- Reader FSM states:
  - R_IDLE: on bank `rb` being FULL, mark it READING, set `raddr` = 0, issue the RAM read, go to R_RUN.
  - R_RUN: present `mem[rb][raddr]`, advancing on each transfer.
  - After the transfer with `olast`, bank `rb` becomes FREE, `rb` toggles, and the FSM returns to R_IDLE.
- Frames always leave in arrival order: `rb` follows `wb`.
- Same-cycle events:
  - A FREE transition from the reader and a frame-start check by the writer on the same bank: the check sees FREE; the frame is accepted.
  - Writer FULL and reader R_IDLE check on the same cycle: the reader sees FULL one cycle later; no sample is lost.

## Timing
- Reset values: `oen`=0, `olast`=0, `oaddr`=0, `odata`=0, `ovf`=0.
- Reset state: banks FREE, `wcnt`=0, `wb`=`rb`=0, reader in R_IDLE.
- Reset mid-frame discards all stored and in-flight data; the next `ien` is treated as frame start.
- Latency: the N-th write is sampled at cycle t; the bank is FULL at t+1; the first `oen` (oaddr 0) is at t+2.
- With `ordy` held high, `oen` stays high for N consecutive cycles with `oaddr` 0..N-1.
  - Back-to-back full frames stream with one idle `oen` cycle between frames (the R_IDLE cycle).
- `ordy` low while `oen` is high: `oaddr`, `odata` and `olast` hold stable. The RAM read address is not advanced; the next read is issued on the transfer cycle.
- `oen` never drops without a transfer.

## Configuration
- `FFT_REORDER_OVF_EN` defined:
  - DROP-mode detection is active.
  - `ovf` sets on the first dropped frame start and stays set until `rst`.
- Undefined:
  - No bank-availability check; `ovf` is tied 0.
  - At frame start the writer always takes bank `wb`. If that bank is FULL or READING, its data is overwritten, and a READING bank may emit mixed frames.
  - Integration guarantees consumer throughput ≥ input rate.

## Test plan
- FFT_STG=3, `ordy`=1: feed `iaddr` 0..7 with `idata`=bitrev(iaddr)+0x10 -> `oaddr` 0..7 and `odata` 0x10..0x17 on consecutive cycles; first `oen` 2 cycles after the 8th `ien`; `olast` only at oaddr 7.
- FFT_STG=3: three back-to-back frames with `ordy`=1 -> 24 natural-order outputs, one idle cycle between frames, `ovf`=0.
- FFT_STG=3: `ordy` toggled 1,0,0,1 during drain -> outputs hold while `ordy`=0; the sequence 0..7 is complete with no duplicates or gaps.
- FFT_STG=3, macro on: hold `ordy`=0 and send 3 frames -> frames 1 and 2 are stored, frame 3 is dropped, `ovf`=1; releasing `ordy` yields exactly frames 1 and 2.
- FFT_STG=3: assert `rst` after 5 samples of a frame -> all outputs 0 the next cycle; the following full frame drains correctly starting from `oaddr` 0.
- FFT_STG=3: write index 1 twice (0xAA then 0xBB) within 8 samples -> the frame completes after 8 samples and `oaddr` 4 carries 0xBB.
